cp0_interrupt_unit: RTL and testbench

CP0_INTERRUPT_UNIT -- requirements
Module: cp0_interrupt_unit

---
 rtl/cp0_interrupt_unit.sv | 63 ++++++
 tb/tb_cp0_interrupt_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/cp0_interrupt_unit.sv
// cp0_interrupt_unit: edge-captured, masked, non-nesting interrupt controller with EPC/ERET support.
module cp0_interrupt_unit #(
  parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] current_pc,
  input  logic [7:0]  hardware_interrupt,
  input  logic        eret,
  output logic        pc_jump,
  output logic [31:0] pc_addr,
  output logic        writeback_mask,
  output logic [31:0] status,
  output logic [31:0] epc,
  output logic        interrupt
);
  logic        r_ie;
  logic [7:0]  r_im;
  logic [2:0]  r_cause;
  logic [31:0] r_epc;
  logic [7:0]  r_prev;
  logic [7:0]  r_pending;
  logic [7:0]  w_req;
  logic [2:0]  w_idx;
  logic [7:0]  w_clr;
  logic        w_take;
  assign w_req  = r_pending & r_im;
  assign w_take = r_ie & (|w_req) & ~eret;
  always_comb begin
    w_idx = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (w_req[k]) w_idx = k[2:0];
  end
  assign w_clr = w_take ? (8'd1 << w_idx) : 8'd0;
  always_comb begin
    pc_jump        = w_take | eret;
    pc_addr        = eret ? r_epc : (w_take ? HANDLER_VECTOR : 32'h0);
    writeback_mask = ~w_take;
  end
  assign interrupt = w_take;
  assign status    = {13'd0, r_cause, r_im, 7'd0, r_ie};
  assign epc       = r_epc;
  // a fresh rising edge on the line being serviced keeps it pending
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ie      <= 1'b1;
      r_im      <= 8'hFF;
      r_cause   <= 3'd0;
      r_epc     <= 32'h0;
      r_prev    <= 8'h0;
      r_pending <= 8'h0;
    end else begin
      r_prev    <= hardware_interrupt;
      r_pending <= (r_pending & ~w_clr) | (hardware_interrupt & ~r_prev);
      if (eret) r_ie <= 1'b1;
      else if (w_take) begin
        r_ie    <= 1'b0;
        r_epc   <= current_pc;
        r_cause <= w_idx;
      end
    end
  end
endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// tb_cp0_interrupt_unit: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_cp0_interrupt_unit;
  logic        clk = 0;
  logic        clr = 0;
  logic [31:0] current_pc = 0;
  logic [7:0]  hardware_interrupt = 0;
  logic        eret = 0;
  logic        pc_jump, writeback_mask, interrupt;
  logic [31:0] pc_addr, status, epc;
  int checks = 0, failures = 0;
  typedef struct {
    string       n;
    logic        pj;
    logic [31:0] pa;
    logic        wb;
    logic        it;
    logic [31:0] st;
    logic [31:0] ep;
  } exp_t;
  exp_t q[$];
  cp0_interrupt_unit #(.HANDLER_VECTOR(32'h100)) dut (
    .clk(clk), .clr(clr), .current_pc(current_pc), .hardware_interrupt(hardware_interrupt),
    .eret(eret), .pc_jump(pc_jump), .pc_addr(pc_addr), .writeback_mask(writeback_mask),
    .status(status), .epc(epc), .interrupt(interrupt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", n, f, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk(x.n, "pc_jump", {31'd0, pc_jump}, {31'd0, x.pj});
      chk(x.n, "pc_addr", pc_addr, x.pa);
      chk(x.n, "writeback_mask", {31'd0, writeback_mask}, {31'd0, x.wb});
      chk(x.n, "interrupt", {31'd0, interrupt}, {31'd0, x.it});
      chk(x.n, "status", status, x.st);
      chk(x.n, "epc", epc, x.ep);
    end
  end
  task automatic cyc(input string n, input logic c, input logic [7:0] hw, input logic e,
                     input logic [31:0] pc, input logic pj, input logic [31:0] pa,
                     input logic wb, input logic it, input logic [31:0] st, input logic [31:0] ep);
    exp_t x;
    @(posedge clk);
    #1;
    clr = c;
    hardware_interrupt = hw;
    eret = e;
    current_pc = pc;
    x.n = n; x.pj = pj; x.pa = pa; x.wb = wb; x.it = it; x.st = st; x.ep = ep;
    q.push_back(x);
  endtask
  initial begin
    cyc("reset",    0, 8'h00, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0000FF01, 32'h0);
    for (int i = 0; i < 10; i++)
      cyc("idle",   1, 8'h00, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0000FF01, 32'h0);
    cyc("raise3",   1, 8'h08, 0, 32'h20,  0, 32'h0,   1, 0, 32'h0000FF01, 32'h0);
    cyc("take3",    1, 8'h08, 0, 32'h20,  1, 32'h100, 0, 1, 32'h0000FF01, 32'h0);
    cyc("eret3",    1, 8'h08, 1, 32'h100, 1, 32'h20,  1, 0, 32'h0003FF00, 32'h20);
    cyc("noretake", 1, 8'h08, 0, 32'h24,  0, 32'h0,   1, 0, 32'h0003FF01, 32'h20);
    cyc("pulse52",  1, 8'h24, 0, 32'h40,  0, 32'h0,   1, 0, 32'h0003FF01, 32'h20);
    cyc("take2",    1, 8'h00, 0, 32'h40,  1, 32'h100, 0, 1, 32'h0003FF01, 32'h20);
    cyc("nonest",   1, 8'h00, 0, 32'h100, 0, 32'h0,   1, 0, 32'h0002FF00, 32'h40);
    cyc("eret2",    1, 8'h00, 1, 32'h104, 1, 32'h40,  1, 0, 32'h0002FF00, 32'h40);
    cyc("take5",    1, 8'h00, 0, 32'h44,  1, 32'h100, 0, 1, 32'h0002FF01, 32'h40);
    cyc("eret5",    1, 8'h00, 1, 32'h100, 1, 32'h44,  1, 0, 32'h0005FF00, 32'h44);
    cyc("raise1",   1, 8'h02, 0, 32'h50,  0, 32'h0,   1, 0, 32'h0005FF01, 32'h44);
    cyc("eretwins", 1, 8'h02, 1, 32'h50,  1, 32'h44,  1, 0, 32'h0005FF01, 32'h44);
    cyc("take1",    1, 8'h02, 0, 32'h54,  1, 32'h100, 0, 1, 32'h0005FF01, 32'h44);
    cyc("handler1", 1, 8'h00, 0, 32'h100, 0, 32'h0,   1, 0, 32'h0001FF00, 32'h54);
    cyc("asyncrst", 0, 8'h80, 0, 32'h100, 0, 32'h0,   1, 0, 32'h0000FF01, 32'h0);
    cyc("release",  1, 8'h80, 0, 32'h60,  0, 32'h0,   1, 0, 32'h0000FF01, 32'h0);
    cyc("take7",    1, 8'h80, 0, 32'h60,  1, 32'h100, 0, 1, 32'h0000FF01, 32'h0);
    cyc("handler7", 1, 8'h80, 0, 32'h100, 0, 32'h0,   1, 0, 32'h0007FF00, 32'h60);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
